// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin owner selection for a single UART transmit path.
// Latches the winner's byte, strobes the transmitter, waits for completion
// (or a watchdog abort), acknowledges and then holds an inter-frame gap.
//
// state  | meaning
// IDLE   | no owner, sampling req
// START  | tx_start strobe to the transmit path
// WAIT   | waiting for tx_done, watchdog running
// GAP    | inter-frame gap, ack/timeout_err pulse on its first cycle
module tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                        tx_done,
    output logic [N_REQ-1:0]            ack,
    output logic [N_REQ-1:0]            grant,
    output logic                        tx_start,
    output logic [DATA_WIDTH-1:0]       tx_data,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [2:0]                  current_state
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        win_q, win_d;
    logic [N_REQ-1:0]        grant_q, grant_d;
    logic [N_REQ-1:0]        ack_q, ack_d;
    logic                    tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    busy_q, busy_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;

    logic                    rr_valid;
    logic [PTR_W-1:0]        rr_sel;
    logic [PTR_W:0]          rr_idx;
    logic [PTR_W-1:0]        ptr_next;
    logic [TO_W-1:0]         to_cnt_inc;

    // Round-robin search: first set req bit starting at ptr, wrapping mod N_REQ.
    always_comb begin
        rr_valid = 1'b0;
        rr_sel   = '0;
        rr_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rr_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (rr_idx >= (PTR_W+1)'(N_REQ)) begin
                rr_idx = rr_idx - (PTR_W+1)'(N_REQ);
            end
            if (!rr_valid && req[rr_idx[PTR_W-1:0]]) begin
                rr_valid = 1'b1;
                rr_sel   = rr_idx[PTR_W-1:0];
            end
        end
    end

    assign ptr_next   = (win_q == PTR_W'(N_REQ-1)) ? '0 : win_q + PTR_W'(1);
    assign to_cnt_inc = to_cnt_q + TO_W'(1);

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        win_d         = win_q;
        grant_d       = grant_q;
        ack_d         = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        timeout_err_d = 1'b0;
        to_cnt_d      = to_cnt_q;
        gap_cnt_d     = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                grant_d   = '0;
                tx_data_d = '0;
                if (rr_valid) begin
                    state_d         = S_START;
                    win_d           = rr_sel;
                    grant_d[rr_sel] = 1'b1;
                    tx_data_d       = req_data[int'(rr_sel)*DATA_WIDTH +: DATA_WIDTH];
                    tx_start_d      = 1'b1;
                    to_cnt_d        = '0;
                end
            end
            S_START: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                to_cnt_d = to_cnt_inc;
                // tx_done takes priority over a watchdog expiring on the same cycle
                if (tx_done) begin
                    ack_d     = grant_q;
                    ptr_d     = ptr_next;
                    grant_d   = '0;
                    gap_cnt_d = GAP_W'(GAP_CYCLES-1);
                    state_d   = S_GAP;
                end else if (to_cnt_inc == TO_W'(TIMEOUT_CYCLES-1)) begin
                    timeout_err_d = 1'b1;
                    ptr_d         = ptr_next;
                    grant_d       = '0;
                    gap_cnt_d     = GAP_W'(GAP_CYCLES-1);
                    state_d       = S_GAP;
                end
            end
            S_GAP: begin
                grant_d = '0;
                if (gap_cnt_q == '0) begin
                    state_d   = S_IDLE;
                    tx_data_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                grant_d   = '0;
                tx_data_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            win_q         <= '0;
            grant_q       <= '0;
            ack_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
            grant_q       <= grant_d;
            ack_q         <= ack_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign ack           = ack_q;
    assign grant         = grant_q;
    assign tx_start      = tx_start_q;
    assign tx_data       = tx_data_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;
    assign current_state = state_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Testbench for tx_arbiter: directed frames, scoreboard queue of expected
// tx_start / ack / timeout_err events consumed by a negedge monitor.
module tb_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 2;
    localparam int TO  = 16;

    localparam logic [1:0] K_START = 2'd0;
    localparam logic [1:0] K_ACK   = 2'd1;
    localparam logic [1:0] K_TO    = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] grant;
        logic [7:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic          tx_done;
    logic [N-1:0]  ack, grant;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          busy, timeout_err;
    logic [2:0]    current_state;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tx_arbiter #(
        .N_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .tx_done(tx_done), .ack(ack), .grant(grant), .tx_start(tx_start),
        .tx_data(tx_data), .busy(busy), .timeout_err(timeout_err),
        .current_state(current_state)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [3:0] g, input logic [7:0] d);
        exp_t e;
        e.kind  = k;
        e.grant = g;
        e.data  = d;
        sb.push_back(e);
    endtask

    // Monitor: every DUT event must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (tx_start) begin
            if (sb.size() == 0) chk("unexpected_tx_start", 32'(1), 32'(0));
            else begin
                e = sb.pop_front();
                chk("sb_kind_start", 32'(e.kind), 32'(K_START));
                chk("sb_grant", 32'(grant), 32'(e.grant));
                chk("sb_tx_data", 32'(tx_data), 32'(e.data));
            end
        end
        if (ack != '0) begin
            if (sb.size() == 0) chk("unexpected_ack", 32'(ack), 32'(0));
            else begin
                e = sb.pop_front();
                chk("sb_kind_ack", 32'(e.kind), 32'(K_ACK));
                chk("sb_ack", 32'(ack), 32'(e.grant));
            end
        end
        if (timeout_err) begin
            if (sb.size() == 0) chk("unexpected_timeout_err", 32'(1), 32'(0));
            else begin
                e = sb.pop_front();
                chk("sb_kind_timeout", 32'(e.kind), 32'(K_TO));
                chk("sb_timeout_no_ack", 32'(ack), 32'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        req   = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // One complete frame: request in IDLE, tx_done done_after cycles after
    // tx_start, then through the gap back to IDLE.
    task automatic run_frame(input logic [3:0] r, input logic [3:0] g, input logic [7:0] d,
                             input int done_after, input bit scramble, input logic [3:0] next_req);
        logic [31:0] saved;
        saved = req_data;
        req   = r;
        push(K_START, g, d);
        tick();
        chk("start_latency", 32'(tx_start), 32'(1));
        chk("grant_start", 32'(grant), 32'(g));
        chk("busy_start", 32'(busy), 32'(1));
        chk("state_start", 32'(current_state), 32'(1));
        for (int k = 1; k <= done_after; k++) begin
            tick();
            if (scramble && k == 2) begin
                req      = '0;
                req_data = 32'hFFFF_FFFF;
            end
            if (scramble) chk("tx_data_hold", 32'(tx_data), 32'(d));
        end
        tx_done = 1'b1;
        push(K_ACK, g, 8'h00);
        tick();
        tx_done = 1'b0;
        req     = next_req;
        if (scramble) req_data = saved;
        chk("ack", 32'(ack), 32'(g));
        chk("no_timeout_err", 32'(timeout_err), 32'(0));
        chk("state_gap", 32'(current_state), 32'(3));
        chk("grant_gap", 32'(grant), 32'(0));
        chk("busy_gap", 32'(busy), 32'(1));
        tick();
        chk("ack_one_cycle", 32'(ack), 32'(0));
        chk("state_gap2", 32'(current_state), 32'(3));
        tick();
        chk("state_idle", 32'(current_state), 32'(0));
        chk("busy_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] bytes [4];
        logic [3:0] one;
        bytes[0] = 8'h11; bytes[1] = 8'hA5; bytes[2] = 8'h3C; bytes[3] = 8'hC3;
        one      = 4'b0001;
        reset    = 1'b1;
        req      = '0;
        req_data = 32'hC3_3C_A5_11;
        tx_done  = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(current_state), 32'(0));
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_tx_start", 32'(tx_start), 32'(0));
        chk("rst_tx_data", 32'(tx_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_timeout_err", 32'(timeout_err), 32'(0));
        reset = 1'b0;

        // single request
        run_frame(4'b0010, 4'b0010, 8'hA5, 12, 1'b0, 4'b0000);

        // round robin with all requests held
        rst_pulse();
        for (int i = 0; i < 5; i++) begin
            run_frame(4'b1111, one << (i % 4), bytes[i % 4], 3, 1'b0,
                      (i == 4) ? 4'b0000 : 4'b1111);
        end

        // watchdog abort of requester 2, then 3 and 2 both pending
        rst_pulse();
        req = 4'b0100;
        push(K_START, 4'b0100, 8'h3C);
        tick();
        chk("to_start", 32'(tx_start), 32'(1));
        push(K_TO, 4'b0000, 8'h00);
        repeat (15) tick();
        chk("to_not_yet", 32'(timeout_err), 32'(0));
        chk("to_state_wait", 32'(current_state), 32'(2));
        req = 4'b1100;
        tick();
        chk("to_pulse", 32'(timeout_err), 32'(1));
        chk("to_no_ack", 32'(ack), 32'(0));
        chk("to_state_gap", 32'(current_state), 32'(3));
        chk("to_grant_clear", 32'(grant), 32'(0));
        tick();
        chk("to_one_cycle", 32'(timeout_err), 32'(0));
        tick();
        chk("to_idle", 32'(current_state), 32'(0));
        run_frame(4'b1100, 4'b1000, 8'hC3, 4, 1'b0, 4'b1100);
        run_frame(4'b1100, 4'b0100, 8'h3C, 4, 1'b0, 4'b0000);

        // tx_done on the same cycle the watchdog would expire
        run_frame(4'b0001, 4'b0001, 8'h11, TO-1, 1'b0, 4'b0000);

        // reset while in WAIT drops the frame
        req = 4'b0001;
        push(K_START, 4'b0001, 8'h11);
        tick();
        chk("rm_start", 32'(tx_start), 32'(1));
        req = '0;
        repeat (3) tick();
        chk("rm_in_wait", 32'(current_state), 32'(2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_state", 32'(current_state), 32'(0));
        chk("rm_grant", 32'(grant), 32'(0));
        chk("rm_busy", 32'(busy), 32'(0));
        chk("rm_ack", 32'(ack), 32'(0));
        chk("rm_tx_start", 32'(tx_start), 32'(0));
        chk("rm_timeout_err", 32'(timeout_err), 32'(0));
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        chk("rm_late_done_ignored", 32'(ack), 32'(0));
        chk("rm_still_idle", 32'(current_state), 32'(0));

        // data stability: req_data and req change during WAIT
        run_frame(4'b1000, 4'b1000, 8'hC3, 6, 1'b1, 4'b0000);

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
